// File: rtl/mem_arbiter.sv
// Two-port line arbiter: shares one memory port between the I-cache and D-cache,
// serving one transaction at a time with alternating priority on ties.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [LINE_W-1:0] ic_wdata,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic                last_dc_r;     // 1: D-cache was served last
    logic                cur_dc_r;      // owner of the transaction in flight
    logic                mem_read_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [LINE_W-1:0]   mem_wdata_r;
    logic [LINE_W-1:0]   ic_rdata_r;
    logic [LINE_W-1:0]   dc_rdata_r;
    logic                ic_ready_r;
    logic                dc_ready_r;

    logic                ic_req_s;
    logic                dc_req_s;
    logic                grant_dc_s;
    logic                grant_write_s;
    logic [ADDR_W-1:0]   grant_addr_s;
    logic [LINE_W-1:0]   grant_wdata_s;

    // Winner selection and request mux; a tie goes to the cache not served last.
    always_comb begin
        ic_req_s      = ic_read | ic_write;
        dc_req_s      = dc_read | dc_write;
        grant_dc_s    = 1'b0;
        grant_write_s = 1'b0;
        grant_addr_s  = {ADDR_W{1'b0}};
        grant_wdata_s = {LINE_W{1'b0}};
        if (dc_req_s && (!ic_req_s || !last_dc_r)) begin
            grant_dc_s = 1'b1;
        end else begin
            grant_dc_s = 1'b0;
        end
        if (grant_dc_s) begin
            grant_write_s = dc_write;
            grant_addr_s  = dc_addr;
            grant_wdata_s = dc_wdata;
        end else begin
            grant_write_s = ic_write;
            grant_addr_s  = ic_addr;
            grant_wdata_s = ic_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (ic_req_s || dc_req_s) begin
                    state_next_s = GRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                if (mem_ready) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = GRANT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latching, memory strobes, read-data capture and ready pulses.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            last_dc_r   <= 1'b1;
            cur_dc_r    <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {LINE_W{1'b0}};
            ic_rdata_r  <= {LINE_W{1'b0}};
            dc_rdata_r  <= {LINE_W{1'b0}};
            ic_ready_r  <= 1'b0;
            dc_ready_r  <= 1'b0;
        end else begin
            ic_ready_r <= 1'b0;
            dc_ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ic_req_s || dc_req_s) begin
                        cur_dc_r    <= grant_dc_s;
                        mem_addr_r  <= grant_addr_s;
                        mem_wdata_r <= grant_wdata_s;
                        mem_write_r <= grant_write_s;
                        mem_read_r  <= ~grant_write_s;
                    end
                end
                GRANT: begin
                    if (mem_ready) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        last_dc_r   <= cur_dc_r;
                        if (cur_dc_r) begin
                            dc_ready_r <= 1'b1;
                            if (mem_read_r) begin
                                dc_rdata_r <= mem_rdata;
                            end
                        end else begin
                            ic_ready_r <= 1'b1;
                            if (mem_read_r) begin
                                ic_rdata_r <= mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign ic_rdata  = ic_rdata_r;
    assign dc_rdata  = dc_rdata_r;
    assign ic_ready  = ic_ready_r;
    assign dc_ready  = dc_ready_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
